// File: rtl/ntsc_capture_wr_pkg.sv
// rtl/ntsc_capture_wr_pkg.sv - shared NTSC buffer geometry, pixel type and capture FSM encoding
package ntsc_capture_wr_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int BUF_W_DEF    = 320;
    localparam int BUF_H_DEF    = 240;
    localparam int BUF_PIX_DEF  = 76800;

    typedef logic [11:0] pixel_t;

    localparam pixel_t BLACK = 12'h000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARMED   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_DONE    = 2'b11
    } capt_state_e;

endpackage

// File: rtl/ntsc_capture_wr_decim.sv
// rtl/ntsc_capture_wr_decim.sv - decim_addr_gen: column/line counters, 2x2 keep decision, buffer address
module decim_addr_gen
    import ntsc_capture_wr_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int BUF_W    = BUF_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    input  logic        i_clear,
    input  logic        i_sol,
    input  logic        i_pix_valid,
    output logic        o_keep,
    output logic [16:0] o_addr
);

    localparam logic [9:0]  H_MAX    = 10'(H_ACTIVE);
    localparam logic [8:0]  V_MAX    = 9'(V_ACTIVE);
    localparam logic [16:0] BUF_W_17 = 17'(BUF_W);

    logic [9:0]  r_hcnt;
    logic [8:0]  r_vcnt;
    logic [16:0] r_line_base;
    logic        r_first;

    logic [9:0]  w_h;
    logic [9:0]  w_h_nxt;
    logic [8:0]  w_v;
    logic [16:0] w_base;
    logic        w_first;

    // Restart and sol are applied before the pixel of the same cycle is classified.
    always_comb begin
        w_h     = r_hcnt;
        w_v     = r_vcnt;
        w_base  = r_line_base;
        w_first = r_first;
        if (i_clear) begin
            w_h     = '0;
            w_v     = '0;
            w_base  = '0;
            w_first = 1'b1;
        end
        if (i_sol) begin
            w_h = '0;
            if (w_first) begin
                w_first = 1'b0;
            end else if (w_v < V_MAX) begin
                w_v = w_v + 9'd1;
                if (!w_v[0] && (w_v < V_MAX)) begin
                    w_base = w_base + BUF_W_17;
                end
            end
        end
        o_keep  = i_en && i_pix_valid && (w_h < H_MAX) && (w_v < V_MAX) && !w_h[0] && !w_v[0];
        o_addr  = w_base + {8'd0, w_h[9:1]};
        w_h_nxt = (i_pix_valid && (w_h < H_MAX)) ? (w_h + 10'd1) : w_h;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            r_line_base <= '0;
            r_first     <= 1'b0;
        end else if (i_en) begin
            r_hcnt      <= w_h_nxt;
            r_vcnt      <= w_v;
            r_line_base <= w_base;
            r_first     <= w_first;
        end
    end

endmodule

// File: rtl/ntsc_capture_wr.sv
// rtl/ntsc_capture_wr.sv - single-frame 2x2 decimating capture into ntsc_buf
module ntsc_capture_wr
    import ntsc_capture_wr_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int BUF_W    = BUF_W_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sof,
    input  logic        sol,
    input  logic        pix_valid,
    input  pixel_t      pix_data,
    input  logic        frame_req,
    output logic        ntsc_in_wr,
    output logic [16:0] ntsc_in_addr,
    output pixel_t      ntsc_in_data,
    output logic        frame_ready,
    output logic        busy,
    output logic        capt_err
);

    localparam logic [16:0] LAST_ADDR = 17'(BUF_W * (V_ACTIVE / 2) - 1);

    capt_state_e r_state;
    logic        r_wr;
    logic [16:0] r_addr;
    pixel_t      r_data;
    logic        r_frame_ready;
    logic        r_busy;
    logic        r_capt_err;

    logic        w_en;
    logic        w_clear;
    logic        w_keep;
    logic [16:0] w_addr;

    // The sof that arms a capture also accepts its own pixel, exactly like an early restart.
    assign w_en    = (r_state == ST_CAPTURE) || ((r_state == ST_ARMED) && sof);
    assign w_clear = sof && ((r_state == ST_ARMED) || (r_state == ST_CAPTURE));

    decim_addr_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .BUF_W    (BUF_W)
    ) u_decim (
        .clk         (clk),
        .rst_n       (reset_n),
        .i_en        (w_en),
        .i_clear     (w_clear),
        .i_sol       (sol),
        .i_pix_valid (pix_valid),
        .o_keep      (w_keep),
        .o_addr      (w_addr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_wr          <= 1'b0;
            r_addr        <= '0;
            r_data        <= BLACK;
            r_frame_ready <= 1'b0;
            r_busy        <= 1'b0;
            r_capt_err    <= 1'b0;
        end else begin
            r_wr          <= 1'b0;
            r_frame_ready <= 1'b0;
            if (w_keep) begin
                r_wr   <= 1'b1;
                r_addr <= w_addr;
                r_data <= pix_data;
            end
            case (r_state)
                ST_IDLE: begin
                    if (frame_req) begin
                        r_state <= ST_ARMED;
                        r_busy  <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (sof) begin
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (sof) begin
                        r_capt_err <= 1'b1;
                    end else if (w_keep && (w_addr == LAST_ADDR)) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_frame_ready <= 1'b1;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign ntsc_in_wr   = r_wr;
    assign ntsc_in_addr = r_addr;
    assign ntsc_in_data = r_data;
    assign frame_ready  = r_frame_ready;
    assign busy         = r_busy;
    assign capt_err     = r_capt_err;

endmodule

// File: tb/tb_ntsc_capture_wr.sv
// tb/tb_ntsc_capture_wr.sv - scoreboard bench for ntsc_capture_wr on a reduced 16x128 geometry
module tb_ntsc_capture_wr;

    localparam int H  = 16;
    localparam int V  = 128;
    localparam int BW = 8;
    localparam int NPIX = BW * (V / 2);
    localparam int LAST = NPIX - 1;

    localparam int M_IDLE = 0, M_ARMED = 1, M_CAPT = 2, M_DONE = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sof, sol, pix_valid, frame_req;
    logic [11:0] pix_data;
    logic        ntsc_in_wr;
    logic [16:0] ntsc_in_addr;
    logic [11:0] ntsc_in_data;
    logic        frame_ready, busy, capt_err;

    int n_vec = 0;
    int n_err = 0;

    int m_st, m_line, m_col;
    logic m_first, m_err;
    logic [28:0] q[$];

    int          seg_writes;
    logic [16:0] seg_first_addr;
    logic [11:0] seg_first_data;
    logic [16:0] last_addr;
    int          fr_cnt;
    logic [11:0] mem [NPIX];

    ntsc_capture_wr #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .BUF_W    (BW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sof          (sof),
        .sol          (sol),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .frame_req    (frame_req),
        .ntsc_in_wr   (ntsc_in_wr),
        .ntsc_in_addr (ntsc_in_addr),
        .ntsc_in_data (ntsc_in_data),
        .frame_ready  (frame_ready),
        .busy         (busy),
        .capt_err     (capt_err)
    );

    always #5 clk = ~clk;

    task automatic seg_clear();
        seg_writes     = 0;
        seg_first_addr = '1;
        seg_first_data = '1;
        last_addr      = '1;
        fr_cnt         = 0;
    endtask

    // One clock of stimulus: model predicts, DUT is sampled on the following falling edge.
    task automatic drive(input logic s_sof, input logic s_sol, input logic s_pv,
                         input logic [11:0] s_d, input logic s_req);
        logic        exp_fr;
        logic        exp_busy;
        logic [16:0] ea;
        logic [28:0] e;
        sof = s_sof; sol = s_sol; pix_valid = s_pv; pix_data = s_d; frame_req = s_req;
        exp_fr = 1'b0;
        case (m_st)
            M_IDLE:  if (s_req) m_st = M_ARMED;
            M_ARMED: if (s_sof) begin m_st = M_CAPT; m_line = 0; m_col = 0; m_first = 1'b1; end
            M_CAPT:  if (s_sof) begin m_err = 1'b1; m_line = 0; m_col = 0; m_first = 1'b1; end
            default: begin exp_fr = 1'b1; m_st = M_IDLE; end
        endcase
        if (m_st == M_CAPT) begin
            if (s_sol) begin
                if (m_first) m_first = 1'b0;
                else if (m_line < V) m_line++;
                m_col = 0;
            end
            if (s_pv) begin
                if (m_col < H && m_line < V && (m_col % 2) == 0 && (m_line % 2) == 0) begin
                    ea = 17'((m_line / 2) * BW + m_col / 2);
                    q.push_back({ea, s_d});
                    if (ea == 17'(LAST)) m_st = M_DONE;
                end
                if (m_col < H) m_col++;
            end
        end
        @(negedge clk);
        if (ntsc_in_wr) begin
            if (seg_writes == 0) begin
                seg_first_addr = ntsc_in_addr;
                seg_first_data = ntsc_in_data;
            end
            seg_writes++;
            last_addr = ntsc_in_addr;
            if (ntsc_in_addr < 17'(NPIX)) mem[ntsc_in_addr] = ntsc_in_data;
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                if (n_err < 20) $display("FAIL unexpected_wr got addr=%0d data=%h, required no write", ntsc_in_addr, ntsc_in_data);
            end else begin
                e = q.pop_front();
                if ({ntsc_in_addr, ntsc_in_data} !== e) begin
                    n_err++;
                    if (n_err < 20) $display("FAIL wr_payload got addr=%0d data=%h, required addr=%0d data=%h",
                                             ntsc_in_addr, ntsc_in_data, e[28:12], e[11:0]);
                end
            end
        end else if (q.size() != 0) begin
            e = q.pop_front();
            n_vec++;
            n_err++;
            if (n_err < 20) $display("FAIL missing_wr got no write, required addr=%0d data=%h", e[28:12], e[11:0]);
        end
        if (frame_ready) fr_cnt++;
        n_vec++;
        if (frame_ready !== exp_fr) begin
            n_err++;
            if (n_err < 20) $display("FAIL frame_ready got %b, required %b", frame_ready, exp_fr);
        end
        exp_busy = (m_st == M_ARMED) || (m_st == M_CAPT);
        n_vec++;
        if (busy !== exp_busy) begin
            n_err++;
            if (n_err < 20) $display("FAIL busy got %b, required %b", busy, exp_busy);
        end
        n_vec++;
        if (capt_err !== m_err) begin
            n_err++;
            if (n_err < 20) $display("FAIL capt_err got %b, required %b", capt_err, m_err);
        end
    endtask

    task automatic send_line(input int line, input int npix, input int gap_col, input int gap_len,
                             input int req_col, input logic sof_first);
        for (int c = 0; c < npix; c++) begin
            if (c == gap_col) repeat (gap_len) drive(1'b0, 1'b0, 1'b0, 12'h0, 1'b0);
            drive(sof_first && c == 0, c == 0, 1'b1, {line[3:0], c[7:0]}, c == req_col);
        end
        drive(1'b0, 1'b0, 1'b0, 12'h0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 12'h0, 1'b0);
    endtask

    task automatic start_frame();
        drive(1'b0, 1'b0, 1'b0, 12'h0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        sof = 0; sol = 0; pix_valid = 0; pix_data = '0; frame_req = 0;
        m_st = M_IDLE; m_line = 0; m_col = 0; m_first = 1'b0; m_err = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({ntsc_in_wr, ntsc_in_addr, ntsc_in_data, frame_ready, busy, capt_err} !== 33'd0) begin
            n_err++;
            $display("FAIL reset_outputs got wr=%b addr=%0d data=%h fr=%b busy=%b err=%b, required all 0",
                     ntsc_in_wr, ntsc_in_addr, ntsc_in_data, frame_ready, busy, capt_err);
        end
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 12'h0, 1'b0);
    endtask

    task automatic test_full_frame();
        seg_clear();
        start_frame();
        for (int l = 0; l < V; l++) send_line(l, H, (l == 4) ? 6 : -1, 3, -1, 1'b0);
        repeat (4) drive(1'b0, 1'b0, 1'b0, 12'h0, 1'b0);
        n_vec++;
        if (seg_writes != NPIX) begin n_err++; $display("FAIL full_write_count got %0d, required %0d", seg_writes, NPIX); end
        n_vec++;
        if (seg_first_addr !== 17'd0 || seg_first_data !== 12'h000) begin
            n_err++; $display("FAIL full_first_wr got addr=%0d data=%h, required addr=0 data=000", seg_first_addr, seg_first_data);
        end
        n_vec++;
        if (mem[10] !== 12'h204) begin n_err++; $display("FAIL full_line2_col4 got %h, required 204", mem[10]); end
        n_vec++;
        if (last_addr !== 17'(LAST)) begin n_err++; $display("FAIL full_last_addr got %0d, required %0d", last_addr, LAST); end
        n_vec++;
        if (fr_cnt != 1) begin n_err++; $display("FAIL full_frame_ready_count got %0d, required 1", fr_cnt); end
    endtask

    task automatic test_overlong_and_req();
        seg_clear();
        start_frame();
        send_line(0, H, -1, 0, -1, 1'b0);
        send_line(1, H, -1, 0, -1, 1'b0);
        send_line(2, 40, -1, 0, -1, 1'b0);
        n_vec++;
        if (last_addr !== 17'(BW + BW - 1)) begin n_err++; $display("FAIL overlong_stop got %0d, required %0d", last_addr, 2 * BW - 1); end
        send_line(3, H, -1, 0, -1, 1'b0);
        seg_writes = 0;
        send_line(4, H, -1, 0, -1, 1'b0);
        n_vec++;
        if (seg_first_addr !== 17'(2 * BW)) begin n_err++; $display("FAIL overlong_resume got %0d, required %0d", seg_first_addr, 2 * BW); end
        for (int l = 5; l < V; l++) send_line(l, H, -1, 0, (l == 50) ? 3 : ((l == V - 2) ? H - 1 : -1), 1'b0);
        repeat (4) drive(1'b0, 1'b0, 1'b0, 12'h0, 1'b0);
        n_vec++;
        if (fr_cnt != 1) begin n_err++; $display("FAIL req_ignored_frame_ready got %0d, required 1", fr_cnt); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL req_ignored_busy got %b, required 0", busy); end
    endtask

    task automatic test_early_sof();
        seg_clear();
        start_frame();
        for (int l = 0; l < 100; l++) send_line(l, H, -1, 0, -1, 1'b0);
        seg_clear();
        send_line(0, H, -1, 0, -1, 1'b1);
        n_vec++;
        if (capt_err !== 1'b1) begin n_err++; $display("FAIL early_sof_err got %b, required 1", capt_err); end
        n_vec++;
        if (seg_first_addr !== 17'd0) begin n_err++; $display("FAIL early_sof_restart_addr got %0d, required 0", seg_first_addr); end
        for (int l = 1; l < V; l++) send_line(l, H, -1, 0, -1, 1'b0);
        repeat (4) drive(1'b0, 1'b0, 1'b0, 12'h0, 1'b0);
        n_vec++;
        if (seg_writes != NPIX) begin n_err++; $display("FAIL early_sof_count got %0d, required %0d", seg_writes, NPIX); end
        n_vec++;
        if (fr_cnt != 1) begin n_err++; $display("FAIL early_sof_frame_ready got %0d, required 1", fr_cnt); end
    endtask

    task automatic test_idle_sof();
        seg_clear();
        drive(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
        send_line(0, H, -1, 0, -1, 1'b0);
        send_line(1, H, -1, 0, -1, 1'b1);
        n_vec++;
        if (seg_writes != 0 || busy !== 1'b0) begin
            n_err++; $display("FAIL idle_sof got writes=%0d busy=%b, required writes=0 busy=0", seg_writes, busy);
        end
    endtask

    task automatic test_reset_mid();
        seg_clear();
        start_frame();
        for (int l = 0; l < 10; l++) send_line(l, H, -1, 0, -1, 1'b0);
        for (int c = 0; c < 8; c++) drive(1'b0, c == 0, 1'b1, {4'hA, c[7:0]}, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        n_vec++;
        if ({ntsc_in_wr, ntsc_in_addr, ntsc_in_data, frame_ready, busy, capt_err} !== 33'd0) begin
            n_err++;
            $display("FAIL reset_mid_async got wr=%b addr=%0d data=%h fr=%b busy=%b err=%b, required all 0",
                     ntsc_in_wr, ntsc_in_addr, ntsc_in_data, frame_ready, busy, capt_err);
        end
        m_st = M_IDLE; m_err = 1'b0; q.delete();
        sof = 0; sol = 0; pix_valid = 0; frame_req = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seg_clear();
        drive(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
        for (int l = 0; l < 4; l++) send_line(l, H, -1, 0, -1, 1'b0);
        n_vec++;
        if (seg_writes != 0 || fr_cnt != 0) begin
            n_err++; $display("FAIL reset_mid_rearm got writes=%0d fr=%0d, required writes=0 fr=0", seg_writes, fr_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_overlong_and_req();
        test_early_sof();
        test_idle_sof();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
